// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM encoding and sizing constants.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    CHECK   = 2'd3
  } state_t;

  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/instr_mem_loader_byte_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and keeps a running XOR checksum.
module instr_mem_loader_byte_word_packer
  import instr_mem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [7:0]  csum_o,
  output logic        full_o
);

  localparam int unsigned IDX_W = $clog2(WORD_BYTES);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      word_q, word_d;
  logic [7:0]       csum_q, csum_d;

  // Shifting in from the top leaves the first byte in [7:0] after four accepts;
  // the index wraps to zero on the fourth byte, ready for the next word.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    csum_d = csum_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
      csum_d = '0;
    end else if (accept_i) begin
      idx_d  = idx_q + 1'b1;
      word_d = {byte_i, word_q[31:8]};
      csum_d = csum_q ^ byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      word_q <= '0;
      csum_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
      csum_q <= csum_d;
    end
  end

  assign word_o = word_q;
  assign csum_o = csum_q;
  assign full_o = accept_i && (idx_q == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a byte-streamed program image into instruction memory, stalling the core and verifying a closing XOR checksum.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CNT_W-1:0]  Load_Words,
  input  logic              Byte_Valid,
  input  logic [7:0]        Byte_Data,
  output logic              Byte_Ready,
  output logic              Mem_Write_En,
  output logic [ADDR_W-1:0] Mem_Write_Add,
  output logic [31:0]       Mem_Write_Data,
  output logic              Cpu_Hold,
  output logic              Done,
  output logic              Error
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             pk_clear, pk_accept, pk_full;
  logic [31:0]      pk_word;
  logic [7:0]       pk_csum;
  logic             len_ok;

  instr_mem_loader_byte_word_packer u_packer (
    .clk_i    (Clock),
    .rst_i    (Reset),
    .clear_i  (pk_clear),
    .accept_i (pk_accept),
    .byte_i   (Byte_Data),
    .word_o   (pk_word),
    .csum_o   (pk_csum),
    .full_o   (pk_full)
  );

  assign len_ok = (Load_Words != '0) && (Load_Words <= CNT_W'(DEPTH));

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    pk_clear   = 1'b0;
    pk_accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          done_d = 1'b0;
          if (len_ok) begin
            count_d    = Load_Words;
            word_idx_d = '0;
            err_d      = 1'b0;
            hold_d     = 1'b1;
            pk_clear   = 1'b1;
            state_d    = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (Byte_Valid) begin
          pk_accept = 1'b1;
          if (pk_full) state_d = WRITE;
        end
      end
      WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (word_idx_q == count_q - 1'b1) ? CHECK : COLLECT;
      end
      CHECK: begin
        if (Byte_Valid) begin
          // A bad image keeps the core held so it never executes.
          if (Byte_Data == pk_csum) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign Byte_Ready     = (state_q == COLLECT) || (state_q == CHECK);
  assign Mem_Write_En   = (state_q == WRITE);
  assign Mem_Write_Add  = ADDR_W'(word_idx_q) << 2;
  assign Mem_Write_Data = pk_word;
  assign Cpu_Hold       = hold_q;
  assign Done           = done_q;
  assign Error          = err_q;

endmodule
